analyse_data: RTL and testbench
===============================

// Module: analyse_data
// PURPOSE
//  Receive side of the SWIPT data link (program 2'b11). Slices the 12-bit ADC current sample against
//  a mean threshold into a serial bit (din), then hunts, samples and decodes one 28-bit response frame.
//  Delivers mode, type, 8-bit payload and checksum status to the link controller with a 1-cycle ready pulse.
// PARAMETERS
//  BIT_CLKS  200000  clocks per line bit (2 ms at 100 MHz); must be even and >=4
//  HYST      12'd16  slicer hysteresis in ADC LSBs around mean_def
// PORTS
//  clk           in   1   system clock
//  nrst          in   1   asynchronous active-low reset
//  swiptAlive    in   1   link enable; 0 = synchronous clear to idle
//  program       in   2   operating program; any value other than 2'b11 = synchronous clear
//  readDataIn    in   1   receive window open; 0 = abandon any frame, return to IDLE
//  ADC           in   12  unsigned current sample
//  mean_def      in   12  unsigned slicer threshold
//  mode          out  2   decoded mode field (held until next valid frame)
//  type          out  2   decoded type field (held)
//  dataIn        out  8   decoded payload, MSB first on the line (held)
//  sumChecker    out  8   ones-count of bits 6..25 of the last valid frame, mod 256 (held)
//  checkSumBit   out  1   1 = received parity equals ^dataIn (held)
//  dataInReady   out  1   1-cycle pulse when a frame passes framing checks
// BEHAVIOUR
//  Reset (nrst=0, async) and sync clear: all outputs 0, din 0, FSM IDLE, counters 0.
//  Slicer: din<=1 when ADC > mean_def+HYST; din<=0 when ADC < mean_def-HYST (saturating 13-bit math); else hold.
//  Frame, MSB first, 28 bits: 6'b101010 | ~m1,m1,~m0,m0 | ~t1,t1,~t0,t0 | d[7:0] | ~p,p | 4'b0101.
//  FSM IDLE: wait readDataIn=1 -> HUNT.
//  HUNT: on din 0->1 edge -> SYNC, phase counter cleared.
//  SYNC: after BIT_CLKS/2 clocks sample bit0; if 0 -> HUNT; else -> SAMPLE.
//  SAMPLE: sample every BIT_CLKS clocks thereafter into 28-bit shift register; after bit 27 -> CHECK.
//  CHECK (1 cycle): preamble=101010, each complementary pair differs, tail=0101;
//   pass: latch mode/type/dataIn/sumChecker, checkSumBit=(p==^d), dataInReady=1 this cycle only, -> IDLE
//   (regardless of readDataIn; returns to HUNT next cycle if still high);
//   fail: no output update, no pulse, -> HUNT.
//  Parity mismatch is not a framing failure: pulse still issued with checkSumBit=0.
//  readDataIn falling mid-frame: immediate IDLE, partial frame discarded, outputs unchanged.
//  Sync clear mid-frame dominates everything; outputs return to 0.
//  Latency: dataInReady asserts 1 cycle after the bit-27 sample instant.
// CONFIGURATION
//  ANALYSE_DATA_RESYNC_EN defined: in SAMPLE, every din transition reloads the phase counter so the
//   next sample falls BIT_CLKS/2 after the edge (tolerates clock drift).
//  Not defined: free-running BIT_CLKS sample grid from the SYNC edge only.
// STRUCTURE
//  Shared package: FSM state enum (IDLE,HUNT,SYNC,SAMPLE,CHECK), FRAME_BITS=28, PREAMBLE=6'b101010,
//   TAIL=4'b0101, field bit positions.
//  Sub-module read_data: ADC/mean_def hysteresis slicer producing registered din
//   (ports clk,nrst,swiptAlive,program,readDataIn,ADC,mean_def,din); din clears when readDataIn=0.
// TESTING (BIT_CLKS=16, HYST=16, mean_def=2048; line 1 = ADC 2200, 0 = ADC 1900)
//  1 Frame m=2'b10,t=2'b01,d=8'hA5,p=0 -> one dataInReady pulse; mode=2,type=1,dataIn=A5,
//    checkSumBit=1, sumChecker=8'd10.
//  2 Same frame with p=1 -> pulse, dataIn=A5, checkSumBit=0.
//  3 Frame with pair bits 7,6 both 1 -> no pulse, outputs keep prior values, FSM back to HUNT.
//  4 readDataIn dropped after 12 bits -> no pulse; next full frame decodes correctly.
//  5 ADC=2060 between slicer thresholds after a 1 -> din stays 1; 1900 -> din 0.
//  6 program=2'b01 or nrst pulse mid-frame -> all outputs 0 next cycle/immediately, no pulse.

Source files
------------

// File: rtl/analyse_data_pkg.sv
// Shared definitions for the SWIPT receive path: FSM states, frame layout and frame checks.
// Register index = 27 - line bit index (the first bit on the line lands in bit 27).
package analyse_data_pkg;

    typedef enum logic [2:0] {IDLE, HUNT, SYNC, SAMPLE, CHECK} state_e;

    localparam int         FRAME_BITS = 28;
    localparam logic [5:0] PREAMBLE   = 6'b101010;
    localparam logic [3:0] TAIL       = 4'b0101;

    localparam int PRE_MSB  = 27;
    localparam int PRE_LSB  = 22;
    localparam int M1_POS   = 20;
    localparam int M0_POS   = 18;
    localparam int T1_POS   = 16;
    localparam int T0_POS   = 14;
    localparam int DATA_MSB = 13;
    localparam int DATA_LSB = 6;
    localparam int PAR_POS  = 4;
    localparam int TAIL_MSB = 3;
    localparam int SUM_HI   = 21;  // line bit 6
    localparam int SUM_LO   = 2;   // line bit 25

    // Each Manchester-style pair carries the complement just above the true bit.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return (f[PRE_MSB:PRE_LSB] == PREAMBLE) && (f[TAIL_MSB:0] == TAIL) &&
               (f[M1_POS+1] != f[M1_POS]) && (f[M0_POS+1] != f[M0_POS]) &&
               (f[T1_POS+1] != f[T1_POS]) && (f[T0_POS+1] != f[T0_POS]) &&
               (f[PAR_POS+1] != f[PAR_POS]);
    endfunction

    function automatic logic [7:0] ones_count(input logic [SUM_HI-SUM_LO:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i <= SUM_HI - SUM_LO; i++) n = n + {7'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/analyse_data_read_data.sv
// Hysteresis slicer: turns the ADC current sample into the registered line bit din.
module read_data #(
    parameter logic [11:0] HYST = 12'd16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        swiptAlive_i,
    input  logic [1:0]  program_i,
    input  logic        readDataIn_i,
    input  logic [11:0] ADC_i,
    input  logic [11:0] mean_def_i,
    output logic        din_o
);

    logic [12:0] thr_hi, thr_lo;
    logic        din_q;

    // 13-bit thresholds: upper cannot wrap, lower clamps at zero.
    assign thr_hi = {1'b0, mean_def_i} + {1'b0, HYST};
    assign thr_lo = (mean_def_i >= HYST) ? {1'b0, mean_def_i - HYST} : 13'd0;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            din_q <= 1'b0;
        end else if (!swiptAlive_i || program_i != 2'b11 || !readDataIn_i) begin
            din_q <= 1'b0;
        end else if ({1'b0, ADC_i} > thr_hi) begin
            din_q <= 1'b1;
        end else if ({1'b0, ADC_i} < thr_lo) begin
            din_q <= 1'b0;
        end
    end

    assign din_o = din_q;

endmodule

// File: rtl/analyse_data.sv
// SWIPT receive frame decoder: hunts, samples and checks one 28-bit frame from the sliced line.
// Build option ANALYSE_DATA_RESYNC_EN re-centres the sample grid on every line transition.
module analyse_data
    import analyse_data_pkg::*;
#(
    parameter int          BIT_CLKS = 200000,
    parameter logic [11:0] HYST     = 12'd16
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        swiptAlive_i,
    input  logic [1:0]  program_i,
    input  logic        readDataIn_i,
    input  logic [11:0] ADC_i,
    input  logic [11:0] mean_def_i,
    output logic [1:0]  mode_o,
    output logic [1:0]  type_o,
    output logic [7:0]  dataIn_o,
    output logic [7:0]  sumChecker_o,
    output logic        checkSumBit_o,
    output logic        dataInReady_o
);

    localparam int HALF = BIT_CLKS / 2;
    localparam int CW   = $clog2(BIT_CLKS + 1);

    logic                  din, din_prev_q, clear;
    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [4:0]            bit_q;
    logic [FRAME_BITS-2:0] sh_q;
    logic [FRAME_BITS-1:0] frame_d;
    logic                  pass_q, ok_d;
    logic [1:0]            mode_q, type_q;
    logic [7:0]            data_q, sum_q;
    logic                  chk_q, ready_q;

    read_data #(.HYST(HYST)) u_slicer (
        .clk_i        (clk_i),
        .nrst_i       (nrst_i),
        .swiptAlive_i (swiptAlive_i),
        .program_i    (program_i),
        .readDataIn_i (readDataIn_i),
        .ADC_i        (ADC_i),
        .mean_def_i   (mean_def_i),
        .din_o        (din)
    );

    assign clear   = !swiptAlive_i || (program_i != 2'b11);
    assign frame_d = {sh_q, din};
    assign ok_d    = frame_ok(frame_d);

    // The frame is judged on the bit-27 sample edge so the pulse lands in the CHECK cycle.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            din_prev_q <= 1'b0; state_q <= IDLE; cnt_q <= '0; bit_q <= '0; sh_q <= '0;
            pass_q <= 1'b0; mode_q <= '0; type_q <= '0; data_q <= '0; sum_q <= '0;
            chk_q <= 1'b0; ready_q <= 1'b0;
        end else if (clear) begin
            din_prev_q <= 1'b0; state_q <= IDLE; cnt_q <= '0; bit_q <= '0; sh_q <= '0;
            pass_q <= 1'b0; mode_q <= '0; type_q <= '0; data_q <= '0; sum_q <= '0;
            chk_q <= 1'b0; ready_q <= 1'b0;
        end else begin
            din_prev_q <= din;
            ready_q    <= 1'b0;
            if (!readDataIn_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: state_q <= HUNT;
                    HUNT: if (din && !din_prev_q) begin
                        state_q <= SYNC;
                        cnt_q   <= CW'(1);
                    end
                    SYNC: if (cnt_q == CW'(HALF)) begin
                        cnt_q   <= CW'(1);
                        bit_q   <= 5'd1;
                        sh_q    <= {{(FRAME_BITS-2){1'b0}}, din};
                        state_q <= din ? SAMPLE : HUNT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    SAMPLE: if (cnt_q == CW'(BIT_CLKS)) begin
                        cnt_q <= CW'(1);
                        sh_q  <= frame_d[FRAME_BITS-2:0];
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 5'(FRAME_BITS - 1)) begin
                            state_q <= CHECK;
                            pass_q  <= ok_d;
                            if (ok_d) begin
                                mode_q  <= {frame_d[M1_POS], frame_d[M0_POS]};
                                type_q  <= {frame_d[T1_POS], frame_d[T0_POS]};
                                data_q  <= frame_d[DATA_MSB:DATA_LSB];
                                sum_q   <= ones_count(frame_d[SUM_HI:SUM_LO]);
                                chk_q   <= (frame_d[PAR_POS] == ^frame_d[DATA_MSB:DATA_LSB]);
                                ready_q <= 1'b1;
                            end
                        end
                    end else begin
`ifdef ANALYSE_DATA_RESYNC_EN
                        cnt_q <= (din != din_prev_q) ? CW'(HALF + 1) : cnt_q + 1'b1;
`else
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                    CHECK:   state_q <= pass_q ? IDLE : HUNT;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mode_o        = mode_q;
    assign type_o        = type_q;
    assign dataIn_o      = data_q;
    assign sumChecker_o  = sum_q;
    assign checkSumBit_o = chk_q;
    assign dataInReady_o = ready_q;

endmodule

// File: tb/tb_analyse_data.sv
// Directed bench for analyse_data: frame table plus hand sequences for abort, slicer and clear cases.
module tb_analyse_data;

    logic        clk = 1'b0;
    logic        nrst, swiptAlive, readDataIn;
    logic [1:0]  program_s;
    logic [11:0] ADC, mean_def;
    logic [1:0]  mode, type_s;
    logic [7:0]  dataIn, sumChecker;
    logic        checkSumBit, dataInReady;

    int n_vec = 0, n_bad = 0, pulses = 0, p0;

    analyse_data #(.BIT_CLKS(16), .HYST(12'd16)) dut (
        .clk_i(clk), .nrst_i(nrst), .swiptAlive_i(swiptAlive), .program_i(program_s),
        .readDataIn_i(readDataIn), .ADC_i(ADC), .mean_def_i(mean_def),
        .mode_o(mode), .type_o(type_s), .dataIn_o(dataIn), .sumChecker_o(sumChecker),
        .checkSumBit_o(checkSumBit), .dataInReady_o(dataInReady)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (dataInReady) pulses++;

    typedef struct {
        logic [1:0] m, t; logic [7:0] d; logic p; logic [27:0] flip; bit mid;
        int exp_pulses; logic [1:0] em, et; logic [7:0] ed, esum; logic echk;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [27:0] mk(input logic [1:0] m, t, input logic [7:0] d, input logic p);
        return {6'b101010, ~m[1], m[1], ~m[0], m[0], ~t[1], t[1], ~t[0], t[0], d, ~p, p, 4'b0101};
    endfunction

    function automatic logic [20:0] pk(input logic [1:0] m, t, input logic [7:0] d, s, input logic c);
        return {m, t, d, s, c};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int nbits);
        ADC = 12'd1900;
        tick(16 * nbits);
    endtask

    // mid=1 drives repeated levels inside the hysteresis band so din must hold.
    task automatic send(input logic [27:0] f, input bit mid, input int nbits);
        logic b, prev;
        prev = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            b = f[27-i];
            if (b) ADC = (mid && prev) ? 12'd2060 : 12'd2200;
            else   ADC = (mid && !prev) ? 12'd2040 : 12'd1900;
            tick(16);
            prev = b;
        end
    endtask

    function automatic logic [20:0] outs();
        return {mode, type_s, dataIn, sumChecker, checkSumBit};
    endfunction

    initial begin
        tbl[0] = '{2'd2, 2'd1, 8'hA5, 1'b0, 28'h0,        1'b0, 1, 2'd2, 2'd1, 8'hA5, 8'd10, 1'b1};
        tbl[1] = '{2'd2, 2'd1, 8'hA5, 1'b1, 28'h0,        1'b0, 1, 2'd2, 2'd1, 8'hA5, 8'd10, 1'b0};
        tbl[2] = '{2'd2, 2'd1, 8'hA5, 1'b0, 28'h0200000,  1'b0, 0, 2'd2, 2'd1, 8'hA5, 8'd10, 1'b0};
        tbl[3] = '{2'd3, 2'd2, 8'h00, 1'b0, 28'h0,        1'b0, 1, 2'd3, 2'd2, 8'h00, 8'd6,  1'b1};
        tbl[4] = '{2'd0, 2'd3, 8'hFF, 1'b0, 28'h0,        1'b1, 1, 2'd0, 2'd3, 8'hFF, 8'd14, 1'b1};
        tbl[5] = '{2'd1, 2'd0, 8'h01, 1'b1, 28'h0,        1'b0, 1, 2'd1, 2'd0, 8'h01, 8'd7,  1'b1};
        tbl[6] = '{2'd1, 2'd0, 8'h80, 1'b0, 28'h0000001,  1'b0, 0, 2'd1, 2'd0, 8'h01, 8'd7,  1'b1};
        tbl[7] = '{2'd1, 2'd0, 8'h80, 1'b0, 28'h0,        1'b0, 1, 2'd1, 2'd0, 8'h80, 8'd7,  1'b0};

        nrst = 1'b1; swiptAlive = 1'b1; program_s = 2'b11; readDataIn = 1'b0;
        ADC = 12'd1900; mean_def = 12'd2048;
        #1 nrst = 1'b0;
        tick(2);
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_ready", 32'(dataInReady), 32'd0);
        nrst = 1'b1;
        tick(2);

        // Slicer hysteresis probe on the internal line bit.
        readDataIn = 1'b1;
        tick(2);
        ADC = 12'd2200; tick(3);
        chk("slicer_hi", 32'(dut.u_slicer.din_o), 32'd1);
        ADC = 12'd2060; tick(4);
        chk("slicer_hold1", 32'(dut.u_slicer.din_o), 32'd1);
        ADC = 12'd1900; tick(3);
        chk("slicer_lo", 32'(dut.u_slicer.din_o), 32'd0);
        ADC = 12'd2040; tick(4);
        chk("slicer_hold0", 32'(dut.u_slicer.din_o), 32'd0);
        idle(32);
        chk("slicer_no_pulse", 32'(pulses), 32'd0);

        for (int v = 0; v < 8; v++) begin
            p0 = pulses;
            send(mk(tbl[v].m, tbl[v].t, tbl[v].d, tbl[v].p) ^ tbl[v].flip, tbl[v].mid, 28);
            idle(3);
            chk($sformatf("vec%0d_pulses", v), 32'(pulses - p0), 32'(tbl[v].exp_pulses));
            chk($sformatf("vec%0d_outs", v), 32'(outs()),
                32'(pk(tbl[v].em, tbl[v].et, tbl[v].ed, tbl[v].esum, tbl[v].echk)));
        end

        // Receive window closes after 12 bits, then a full frame.
        p0 = pulses;
        send(mk(2'd2, 2'd2, 8'h3C, 1'b0), 1'b0, 12);
        readDataIn = 1'b0;
        idle(20);
        chk("abort_pulses", 32'(pulses - p0), 32'd0);
        chk("abort_outs", 32'(outs()), 32'(pk(2'd1, 2'd0, 8'h80, 8'd7, 1'b0)));
        readDataIn = 1'b1;
        idle(2);
        send(mk(2'd2, 2'd2, 8'h3C, 1'b0), 1'b0, 28);
        idle(3);
        chk("after_abort_pulses", 32'(pulses - p0), 32'd1);
        chk("after_abort_outs", 32'(outs()), 32'(pk(2'd2, 2'd2, 8'h3C, 8'd10, 1'b1)));

        // Program change mid-frame clears outputs on the next edge.
        p0 = pulses;
        send(mk(2'd3, 2'd1, 8'h0F, 1'b1), 1'b0, 10);
        program_s = 2'b01;
        tick(1);
        chk("prog_clear_outs", 32'(outs()), 32'd0);
        tick(2);
        program_s = 2'b11;
        idle(30);
        chk("prog_clear_pulses", 32'(pulses - p0), 32'd0);
        chk("prog_clear_hold", 32'(outs()), 32'd0);
        send(mk(2'd3, 2'd1, 8'h0F, 1'b1), 1'b0, 28);
        idle(3);
        chk("post_prog_outs", 32'(outs()), 32'(pk(2'd3, 2'd1, 8'h0F, 8'd10, 1'b0)));

        // Async reset mid-frame clears outputs without waiting for a clock.
        p0 = pulses;
        send(mk(2'd2, 2'd1, 8'hA5, 1'b0), 1'b0, 10);
        #2 nrst = 1'b0;
        #1 chk("nrst_async_outs", 32'(outs()), 32'd0);
        tick(2);
        nrst = 1'b1;
        idle(30);
        chk("nrst_pulses", 32'(pulses - p0), 32'd0);
        chk("nrst_hold", 32'(outs()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
